// File: rtl/blit_cmd_seq_if.sv
// Bus bundle for blit_cmd_seq: the command-FIFO pop interface and the
// per-pixel valid/ready request stream. The master modport is the sequencer's
// view; the slave modport is the view of the FIFO plus pixel pipeline around it.
interface blit_cmd_seq_if;
    logic [103:0] cmd;
    logic         cmd_valid;
    logic         cmd_next;
    logic         pix_valid;
    logic         pix_ready;
    logic [1:0]   pix_op;
    logic [15:0]  pix_x;
    logic [15:0]  pix_y;
    logic [15:0]  pix_src_x;
    logic [15:0]  pix_src_y;
    logic [31:0]  pix_color;

    modport master (
        input  cmd, cmd_valid, pix_ready,
        output cmd_next, pix_valid, pix_op, pix_x, pix_y,
               pix_src_x, pix_src_y, pix_color
    );

    modport slave (
        output cmd, cmd_valid, pix_ready,
        input  cmd_next, pix_valid, pix_op, pix_x, pix_y,
               pix_src_x, pix_src_y, pix_color
    );
endinterface

// File: rtl/blit_cmd_seq.sv
// Blitter command sequencer: pops 104-bit commands from the command FIFO,
// decodes them and expands FILL/COPY rectangles into a row-major stream of
// per-pixel requests. Holds the drawing origin (and clip window when enabled).
// Optional feature macro: BLIT_CLIP_EN (SET_CLIP loads an exclusive clip
// window; pixels outside it are skipped without a handshake). Without it,
// SET_CLIP is accepted as a NOP and every pixel is emitted.
module blit_cmd_seq #(
    parameter int MAX_DIM = 2048
) (
    input  logic           clock,
    input  logic           reset_n,
    blit_cmd_seq_if.master bus,
    output logic           busy,
    output logic           cmd_err
);

    localparam logic [7:0]  OP_NOP    = 8'h00;
    localparam logic [7:0]  OP_ORIGIN = 8'h01;
    localparam logic [7:0]  OP_FILL   = 8'h02;
    localparam logic [7:0]  OP_COPY   = 8'h03;
    localparam logic [7:0]  OP_CLIP   = 8'h04;
    localparam logic [15:0] DIM_MAX   = 16'(MAX_DIM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_RUN
    } state_t;

    state_t      state_q, state_d;

    // Command fields captured on the pop edge (FIFO data goes stale right after).
    logic [7:0]  op_q;
    logic [15:0] x_q, y_q, w_q, h_q;
    logic [31:0] arg_q;

    // Persistent drawing state.
    logic [15:0] ox_q, oy_q;

    // Rectangle walk.
    logic [15:0] we_q, he_q, cnt_x_q, cnt_y_q;

    logic        pop, step, last_pix, is_copy;
    logic        start_rect, set_origin, set_err;
    logic [15:0] we_dec, he_dec, nxt_cx, nxt_cy, dst_x_n, dst_y_n;
    logic        in_clip_n;

`ifdef BLIT_CLIP_EN
    // Upper bounds are 17 bits so the reset window really includes 0xFFFF.
    logic [15:0] clip_x0_q, clip_y0_q;
    logic [16:0] clip_x1_q, clip_y1_q;
    logic        set_clip;
`endif

    assign pop          = (state_q == S_IDLE) && bus.cmd_valid;
    assign bus.cmd_next = pop;
    assign busy         = (state_q != S_IDLE) || bus.pix_valid;

    assign we_dec   = (w_q > DIM_MAX) ? DIM_MAX : w_q;
    assign he_dec   = (h_q > DIM_MAX) ? DIM_MAX : h_q;
    assign is_copy  = (op_q == OP_COPY);
    assign last_pix = (cnt_x_q == we_q - 16'd1) && (cnt_y_q == he_q - 16'd1);
    // A pixel slot retires when it is handshaken or when it was clipped away.
    assign step     = (state_q == S_RUN) && (!bus.pix_valid || bus.pix_ready);

    // Next-state and decode strobes.
    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        start_rect = 1'b0;
        set_origin = 1'b0;
        set_err    = 1'b0;
`ifdef BLIT_CLIP_EN
        set_clip   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pop) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_IDLE;
                case (op_q)
                    OP_NOP:    ;
                    OP_ORIGIN: set_origin = 1'b1;
                    OP_CLIP: begin
`ifdef BLIT_CLIP_EN
                        set_clip = 1'b1;
`endif
                    end
                    OP_FILL, OP_COPY: begin
                        if (w_q != 16'd0 && h_q != 16'd0) begin
                            start_rect = 1'b1;
                            state_d    = S_RUN;
                        end
                    end
                    default:   set_err = 1'b1;
                endcase
            end
            S_RUN: begin
                if (step && last_pix) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Coordinates of the next pixel slot (first slot when a rectangle starts).
    always_comb begin
        nxt_cx = '0;
        nxt_cy = '0;
        if (!start_rect) begin
            if (cnt_x_q == we_q - 16'd1) begin
                nxt_cx = '0;
                nxt_cy = cnt_y_q + 16'd1;
            end else begin
                nxt_cx = cnt_x_q + 16'd1;
                nxt_cy = cnt_y_q;
            end
        end
    end

    // Destination wraps modulo 2^16 by plain 16-bit addition.
    assign dst_x_n = x_q + ox_q + nxt_cx;
    assign dst_y_n = y_q + oy_q + nxt_cy;

`ifdef BLIT_CLIP_EN
    assign in_clip_n = (dst_x_n >= clip_x0_q) && ({1'b0, dst_x_n} < clip_x1_q) &&
                       (dst_y_n >= clip_y0_q) && ({1'b0, dst_y_n} < clip_y1_q);
`else
    assign in_clip_n = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Command capture, drawing state and registered pixel outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the captured command fields are reset along with everything
            // else; they are ordinary flops, so no X can leak into the pixel
            // outputs before the first command arrives.
            op_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            w_q           <= '0;
            h_q           <= '0;
            arg_q         <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            we_q          <= '0;
            he_q          <= '0;
            cnt_x_q       <= '0;
            cnt_y_q       <= '0;
            cmd_err       <= 1'b0;
            bus.pix_valid <= 1'b0;
            bus.pix_op    <= '0;
            bus.pix_x     <= '0;
            bus.pix_y     <= '0;
            bus.pix_src_x <= '0;
            bus.pix_src_y <= '0;
            bus.pix_color <= '0;
`ifdef BLIT_CLIP_EN
            clip_x0_q     <= '0;
            clip_y0_q     <= '0;
            clip_x1_q     <= 17'h10000;
            clip_y1_q     <= 17'h10000;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here
            // sees the pre-edge value of every other one regardless of order.
            if (pop) begin
                op_q  <= bus.cmd[103:96];
                x_q   <= bus.cmd[95:80];
                y_q   <= bus.cmd[79:64];
                w_q   <= bus.cmd[63:48];
                h_q   <= bus.cmd[47:32];
                arg_q <= bus.cmd[31:0];
            end
            if (set_origin) begin
                ox_q <= x_q;
                oy_q <= y_q;
            end
`ifdef BLIT_CLIP_EN
            if (set_clip) begin
                clip_x0_q <= x_q;
                clip_y0_q <= y_q;
                clip_x1_q <= {1'b0, x_q} + {1'b0, w_q};
                clip_y1_q <= {1'b0, y_q} + {1'b0, h_q};
            end
`endif
            if (set_err) cmd_err <= 1'b1;
            if (start_rect) begin
                we_q          <= we_dec;
                he_q          <= he_dec;
                bus.pix_op    <= is_copy ? 2'd2 : 2'd1;
                bus.pix_color <= is_copy ? 32'd0 : arg_q;
            end
            if (start_rect || (step && !last_pix)) begin
                cnt_x_q       <= nxt_cx;
                cnt_y_q       <= nxt_cy;
                bus.pix_x     <= dst_x_n;
                bus.pix_y     <= dst_y_n;
                bus.pix_src_x <= is_copy ? arg_q[31:16] + nxt_cx : 16'd0;
                bus.pix_src_y <= is_copy ? arg_q[15:0] + nxt_cy : 16'd0;
                bus.pix_valid <= in_clip_n;
            end else if (step && last_pix) begin
                bus.pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blit_cmd_seq.sv
// Testbench for blit_cmd_seq: a FIFO model feeds commands, a reference model
// expands each command into expected pixels in a queue, and an independent
// monitor compares every presented pixel against the head of that queue.
module tb_blit_cmd_seq;

    localparam int MAX_DIM = 2048;
    localparam int LIMIT   = 6000;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] sx;
        logic [15:0] sy;
        logic [31:0] color;
    } pix_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic busy, cmd_err;

    blit_cmd_seq_if bus ();

    blit_cmd_seq #(.MAX_DIM(MAX_DIM)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    always #5 clock = ~clock;

    int tests   = 0;
    int fails   = 0;
    int cyc     = 0;
    int hs_cnt  = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by the test

    logic [103:0] fifo_q[$];
    pix_t         exp_q[$];

    // Reference model state.
    logic [15:0] m_ox = '0, m_oy = '0;
    int          m_cx0 = 0, m_cy0 = 0, m_cx1 = 65536, m_cy1 = 65536;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ox  = '0;
        m_oy  = '0;
        m_cx0 = 0;
        m_cy0 = 0;
        m_cx1 = 65536;
        m_cy1 = 65536;
    endtask

    // Queue a command into the FIFO and push the pixels it must produce.
    task automatic push_cmd(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] w, input logic [15:0] h, input logic [31:0] arg);
        int          we, he;
        pix_t        p;
        logic [15:0] dx, dy;
        fifo_q.push_back({op, x, y, w, h, arg});
        case (op)
            8'h01: begin
                m_ox = x;
                m_oy = y;
            end
`ifdef BLIT_CLIP_EN
            8'h04: begin
                m_cx0 = int'(x);
                m_cy0 = int'(y);
                m_cx1 = int'(x) + int'(w);
                m_cy1 = int'(y) + int'(h);
            end
`endif
            8'h02, 8'h03: begin
                we = (int'(w) > MAX_DIM) ? MAX_DIM : int'(w);
                he = (int'(h) > MAX_DIM) ? MAX_DIM : int'(h);
                for (int r = 0; r < he; r++) begin
                    for (int c = 0; c < we; c++) begin
                        dx = 16'(int'(x) + int'(m_ox) + c);
                        dy = 16'(int'(y) + int'(m_oy) + r);
                        if (int'(dx) >= m_cx0 && int'(dx) < m_cx1 &&
                            int'(dy) >= m_cy0 && int'(dy) < m_cy1) begin
                            p.op    = (op == 8'h02) ? 2'd1 : 2'd2;
                            p.x     = dx;
                            p.y     = dy;
                            p.sx    = (op == 8'h03) ? 16'(int'(arg[31:16]) + c) : 16'd0;
                            p.sy    = (op == 8'h03) ? 16'(int'(arg[15:0]) + r) : 16'd0;
                            p.color = (op == 8'h02) ? arg : 32'd0;
                            exp_q.push_back(p);
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(fifo_q.size() == 0 && !bus.cmd_valid && !busy) && n < LIMIT);
        check({name, " reached idle"}, 128'(n < LIMIT), 128'(1));
        check({name, " missing pixels"}, 128'(exp_q.size()), 128'(0));
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Command FIFO model: data is garbage for one cycle after each pop.
    initial begin : fifo_drv
        logic         popped;
        logic [127:0] junk;
        bus.cmd       = '0;
        bus.cmd_valid = 1'b0;
        forever begin
            @(negedge clock);
            popped = bus.cmd_next;
            @(posedge clock);
            #1;
            if (popped && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                junk    = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.cmd = junk[103:0];
            end else begin
                bus.cmd = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            end
            bus.cmd_valid = (fifo_q.size() > 0);
        end
    end

    // Pixel-pipeline ready driver.
    initial begin : rdy_drv
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (rdy_mode == 0)      bus.pix_ready = 1'b1;
            else if (rdy_mode == 1) bus.pix_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: every presented pixel must match the scoreboard head.
    initial begin : monitor
        pix_t got;
        forever begin
            @(negedge clock);
            if (reset_n && bus.pix_valid) begin
                got = {bus.pix_op, bus.pix_x, bus.pix_y, bus.pix_src_x, bus.pix_src_y, bus.pix_color};
                if (bus.pix_ready) hs_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected pixel: got 0x%0h, expected none", got);
                end else begin
                    check("pixel", 128'(got), 128'(exp_q[0]));
                    if (bus.pix_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n, t0, h0, pulses, adj;
        logic prev;

        // Reset state.
        #12;
        check("reset outputs",
              128'({bus.cmd_next, bus.pix_valid, busy, cmd_err, bus.pix_op, bus.pix_x,
                    bus.pix_y, bus.pix_src_x, bus.pix_src_y, bus.pix_color}), 128'(0));
        #10 reset_n = 1'b1;
        @(negedge clock);
        check("post-reset busy", 128'(busy), 128'(0));

        // 1: FILL 3x2, first pixel two cycles after the pop strobe.
        h0 = hs_cnt;
        push_cmd(8'h02, 16'd10, 16'd20, 16'd3, 16'd2, 32'hFF00FF00);
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.cmd_next && n < 20);
        t0 = cyc;
        do begin @(negedge clock); n++; end while (!bus.pix_valid && n < 40);
        check("first pixel latency", 128'(cyc - t0), 128'(2));
        wait_idle("fill 3x2");
        check("fill 3x2 count", 128'(hs_cnt - h0), 128'(6));
        check("fill 3x2 busy after", 128'(busy), 128'(0));

        // 2: origin then COPY.
        h0 = hs_cnt;
        push_cmd(8'h01, 16'd100, 16'd50, 16'd0, 16'd0, 32'd0);
        push_cmd(8'h03, 16'd0, 16'd0, 16'd2, 16'd1, 32'h00050007);
        wait_idle("copy");
        check("copy count", 128'(hs_cnt - h0), 128'(2));

        // 3: stalls 1,0,0,1 during a 4-wide FILL.
        rdy_mode = 2;
        bus.pix_ready = 1'b1;
        h0 = hs_cnt;
        push_cmd(8'h02, 16'd7, 16'd9, 16'd4, 16'd1, 32'h12345678);
        n = 0;
        do begin @(negedge clock); n++; end while (!bus.pix_valid && n < 20);
        @(posedge clock); #1 bus.pix_ready = 1'b0;
        @(posedge clock); #1 bus.pix_ready = 1'b0;
        @(posedge clock); #1 bus.pix_ready = 1'b1;
        wait_idle("stall fill");
        check("stall fill count", 128'(hs_cnt - h0), 128'(4));
        rdy_mode = 0;

        // 4: back-to-back NOPs, then an illegal opcode.
        for (int i = 0; i < 4; i++) push_cmd(8'h00, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
        pulses = 0;
        adj    = 0;
        prev   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus.cmd_next) pulses++;
            if (bus.cmd_next && prev) adj++;
            prev = bus.cmd_next;
        end
        check("nop pop pulses", 128'(pulses), 128'(4));
        check("nop pop in decode", 128'(adj), 128'(0));
        wait_idle("nops");
        check("cmd_err before illegal", 128'(cmd_err), 128'(0));
        push_cmd(8'h7F, 16'd1, 16'd2, 16'd3, 16'd4, 32'd5);
        wait_idle("illegal");
        check("cmd_err after illegal", 128'(cmd_err), 128'(1));

        // 5: zero width, clamped width, coordinate wrap.
        push_cmd(8'h01, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
        h0 = hs_cnt;
        push_cmd(8'h02, 16'd5, 16'd5, 16'd0, 16'd5, 32'hAAAA5555);
        wait_idle("zero width");
        check("zero width count", 128'(hs_cnt - h0), 128'(0));
        h0 = hs_cnt;
        push_cmd(8'h02, 16'd0, 16'd1, 16'hFFFF, 16'd1, 32'h0BADF00D);
        wait_idle("clamped width");
        check("clamped width count", 128'(hs_cnt - h0), 128'(2048));
        h0 = hs_cnt;
        push_cmd(8'h02, 16'hFFFF, 16'd3, 16'd2, 16'd1, 32'h00C0FFEE);
        wait_idle("x wrap");
        check("x wrap count", 128'(hs_cnt - h0), 128'(2));

        // Randomized mix with random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int k;
            logic [7:0] op;
            k = $urandom_range(0, 9);
            if (k < 1)      op = 8'h00;
            else if (k < 2) op = 8'h01;
            else if (k < 6) op = 8'h02;
            else if (k < 9) op = 8'h03;
            else            op = 8'h04;
            if (op == 8'h04)
                push_cmd(op, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 32'd0);
            else
                push_cmd(op, 16'($urandom()), 16'($urandom()), 16'($urandom_range(0, 4)),
                         16'($urandom_range(0, 3)), $urandom());
            repeat ($urandom_range(0, 6)) @(negedge clock);
        end
        wait_idle("random");
        check("cmd_err sticky", 128'(cmd_err), 128'(1));
        rdy_mode = 0;

        // 6: asynchronous reset in the second row of a FILL.
        push_cmd(8'h01, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
        push_cmd(8'h02, 16'd200, 16'd300, 16'd3, 16'd3, 32'h55AA55AA);
        n = 0;
        do begin @(negedge clock); n++; end while (!(bus.pix_valid && bus.pix_y == 16'd301) && n < 40);
        check("reached second row", 128'(n < 40), 128'(1));
        #2 reset_n = 1'b0;
        #1;
        check("async reset outputs",
              128'({bus.pix_valid, busy, cmd_err, bus.cmd_next}), 128'(0));
        exp_q.delete();
        fifo_q.delete();
        bus.cmd_valid = 1'b0;
        model_reset();
        #20 reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.pix_valid) n++;
        end
        check("no pixels after reset", 128'(n), 128'(0));

        // Clip window (a plain NOP when clipping is not built in).
        h0 = hs_cnt;
        push_cmd(8'h04, 16'd0, 16'd0, 16'd2, 16'd2, 32'd0);
        push_cmd(8'h02, 16'd1, 16'd1, 16'd3, 16'd3, 32'h00FF00FF);
        wait_idle("clip");
`ifdef BLIT_CLIP_EN
        check("clip count", 128'(hs_cnt - h0), 128'(1));
`else
        check("clip count", 128'(hs_cnt - h0), 128'(9));
`endif
        check("set_clip legal", 128'(cmd_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
